// File: rtl/cpu_pkg.sv
// Shared types and constants for the 4-bit CPU sequencer: control-word layout,
// FSM states and the datapath strobe packing.
package cpu_pkg;

  localparam int unsigned PC_W   = 12;
  localparam int unsigned CTRL_W = 13;
  localparam int unsigned DP_W   = 9;
  localparam int unsigned ADDR_W = 7;

  localparam int unsigned CTRL_INC_PC     = 12;
  localparam int unsigned CTRL_LOAD_PC    = 11;
  localparam int unsigned CTRL_LOAD_FLAGS = 9;

  localparam logic [CTRL_W-1:0] ILLEGAL_WORD = 13'h1FFF;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  // Datapath strobes handed to the ALU/RAM/IO side, in control-word bit order [8:0]
  typedef struct packed {
    logic [2:0] s;
    logic       cs_ram;
    logic       we_ram;
    logic       oe_alu;
    logic       oe_in;
    logic       oe_oprnd;
    logic       load_out;
  } dp_ctrl_t;

  function automatic dp_ctrl_t pack_dp(input logic [CTRL_W-1:0] cw);
    pack_dp = dp_ctrl_t'(cw[DP_W-1:0]);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bus bundle between the sequencer and its ROM, decode table and datapath.
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic              run;
  logic              step;
  logic [7:0]        prog_byte;
  logic              prog_valid;
  logic [PC_W-1:0]   branch_tgt;
  logic              c_in;
  logic              z_in;
  logic [CTRL_W-1:0] ctrl_word;

  logic [ADDR_W-1:0] ctrl_addr;
  logic [PC_W-1:0]   pc;
  logic              fetch_req;
  logic [3:0]        oprnd;
  dp_ctrl_t          dp_ctrl;
  logic              phase;
  logic              halted;
  logic              illegal;

  modport master (
    input  run, step, prog_byte, prog_valid, branch_tgt, c_in, z_in, ctrl_word,
    output ctrl_addr, pc, fetch_req, oprnd, dp_ctrl, phase, halted, illegal
  );

  modport slave (
    output run, step, prog_byte, prog_valid, branch_tgt, c_in, z_in, ctrl_word,
    input  ctrl_addr, pc, fetch_req, oprnd, dp_ctrl, phase, halted, illegal
  );

endinterface

// File: rtl/prog_counter.sv
// Program counter: load beats increment, wraps modulo 2^PC_W.
module prog_counter
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] tgt,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pc <= '0;
    else if (load) pc <= tgt;
    else if (inc)  pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: owns PC, IR, C/Z flags and phase, addresses the
// decode table and gates its control word onto the datapath in EXEC only.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.master bus
);

  state_e          state, state_nxt;
  logic [3:0]      opcode, oprnd_q;
  logic            c_flag, z_flag, illegal_q;
  logic [PC_W-1:0] pc_q;

  logic     is_illegal;
  logic     pc_inc, pc_load, ir_load, flags_load, illegal_set;
  dp_ctrl_t dp_ctrl_c;

  assign is_illegal = (bus.ctrl_word == ILLEGAL_WORD);

  prog_counter u_pc (
    .clk  (clk),
    .reset(reset),
    .inc  (pc_inc),
    .load (pc_load),
    .tgt  (bus.branch_tgt),
    .pc   (pc_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HALT;
    else        state <= state_nxt;
  end

  // An all-ones control word suppresses every update and parks the FSM in HALT
  always_comb begin
    state_nxt   = state;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    ir_load     = 1'b0;
    flags_load  = 1'b0;
    illegal_set = 1'b0;
    dp_ctrl_c   = '0;
    case (state)
      HALT: begin
        if (bus.run || bus.step) state_nxt = FETCH;
      end
      FETCH: begin
        if (is_illegal) begin
          illegal_set = 1'b1;
          state_nxt   = HALT;
        end else if (bus.prog_valid) begin
          ir_load   = 1'b1;
          pc_inc    = bus.ctrl_word[CTRL_INC_PC];
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (is_illegal) begin
          illegal_set = 1'b1;
          state_nxt   = HALT;
        end else begin
          pc_load    = bus.ctrl_word[CTRL_LOAD_PC];
          pc_inc     = bus.ctrl_word[CTRL_INC_PC];
          flags_load = bus.ctrl_word[CTRL_LOAD_FLAGS];
          dp_ctrl_c  = pack_dp(bus.ctrl_word);
          state_nxt  = bus.run ? FETCH : HALT;
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opcode    <= '0;
      oprnd_q   <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (ir_load) {opcode, oprnd_q} <= bus.prog_byte;
      if (flags_load) begin
        c_flag <= bus.c_in;
        z_flag <= bus.z_in;
      end
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  assign bus.ctrl_addr = {opcode, c_flag, z_flag, state == EXEC};
  assign bus.pc        = pc_q;
  assign bus.fetch_req = (state == FETCH);
  assign bus.oprnd     = oprnd_q;
  assign bus.dp_ctrl   = dp_ctrl_c;
  assign bus.phase     = (state == EXEC);
  assign bus.halted    = (state == HALT);
  assign bus.illegal   = illegal_q;

endmodule
